// File: rtl/mux_rr_arb.sv
// -----------------------------------------------------------------------------
// mux_rr_arb
//
// Purpose:
//   N-channel, W-bit stream multiplexer. It has a valid/ready handshake on
//   every input and on the single output. The output is a one-entry
//   registered buffer.
//   Two select modes:
//     - fixed: the channel comes from i_sel.
//     - round-robin: fair arbitration among the valid channels. The search
//       starts at the channel after the last one granted.
//   The buffer can drain and reload in the same cycle, so full throughput is
//   one beat per clock.
//
// Optional feature (compile-time macro MUX_RR_ARB_LOCK_EN):
//   Adds i_in_last. In round-robin mode a beat with last=0 locks the grant
//   to its channel until a beat with last=1 goes through on that channel.
//   Fixed mode ignores the lock.
//
// Parameters:
//   P_NCH   number of input channels (>= 2)
//   P_DW    data width per channel
//   P_SELW  channel index width (derived from P_NCH)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_mode       0 = fixed select via i_sel, 1 = round-robin
//   i_sel        channel index used in fixed mode
//   i_in_data    packed input data; channel k at [k*P_DW +: P_DW]
//   i_in_valid   per-channel valid
//   i_in_last    per-channel end-of-packet (only with MUX_RR_ARB_LOCK_EN)
//   o_in_ready   per-channel ready (combinational, at most one bit set)
//   o_out_data   registered output data
//   o_out_ch     index of the channel that produced o_out_data
//   o_out_valid  output valid
//   i_out_ready  consumer ready
// -----------------------------------------------------------------------------
module mux_rr_arb #(
    parameter int unsigned  P_NCH  = 4,
    parameter int unsigned  P_DW   = 8,
    localparam int unsigned P_SELW = $clog2(P_NCH)
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_mode,
    input  logic [P_SELW-1:0]       i_sel,
    input  logic [P_NCH*P_DW-1:0]   i_in_data,
    input  logic [P_NCH-1:0]        i_in_valid,
`ifdef MUX_RR_ARB_LOCK_EN
    input  logic [P_NCH-1:0]        i_in_last,
`endif
    output logic [P_NCH-1:0]        o_in_ready,
    output logic [P_DW-1:0]         o_out_data,
    output logic [P_SELW-1:0]       o_out_ch,
    output logic                    o_out_valid,
    input  logic                    i_out_ready
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [P_DW-1:0]   data_q,  data_d;
    logic [P_SELW-1:0] ch_q,    ch_d;
    logic              valid_q, valid_d;
    logic [P_SELW-1:0] ptr_q,   ptr_d;   // last channel granted in RR mode

`ifdef MUX_RR_ARB_LOCK_EN
    logic              lock_q,    lock_d;
    logic [P_SELW-1:0] lock_ch_q, lock_ch_d;
`endif

    // -------------------------------------------------------------------------
    // Grant logic
    // -------------------------------------------------------------------------
    logic              load_en;
    logic              sel_in_range;
    logic              fix_gnt_valid;
    logic              rr_gnt_valid;
    logic [P_SELW-1:0] rr_gnt;
    logic              gnt_valid;
    logic [P_SELW-1:0] gnt;
    logic              in_xfer;

    // Buffer takes a beat when empty or when it drains in this same cycle.
    assign load_en = !valid_q || i_out_ready;

    // A non-power-of-two P_NCH leaves some i_sel codes unused. Those codes
    // must never grant.
    assign sel_in_range  = (32'(i_sel) < P_NCH);
    assign fix_gnt_valid = sel_in_range && i_in_valid[i_sel];

    // Rotating priority search. It starts one past the last granted channel.
    always_comb begin
        int unsigned idx;
        rr_gnt_valid = 1'b0;
        rr_gnt       = '0;
        idx          = 0;
        for (int unsigned i = 1; i <= P_NCH; i++) begin
            idx = (32'(ptr_q) + i) % P_NCH;
            if (!rr_gnt_valid && i_in_valid[idx]) begin
                rr_gnt_valid = 1'b1;
                rr_gnt       = idx[P_SELW-1:0];
            end
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        if (!i_mode) begin
            gnt_valid = fix_gnt_valid;
            gnt       = i_sel;
        end else begin
`ifdef MUX_RR_ARB_LOCK_EN
            if (lock_q) begin
                // Mid-packet: only the owning channel may continue.
                gnt_valid = i_in_valid[lock_ch_q];
                gnt       = lock_ch_q;
            end else begin
                gnt_valid = rr_gnt_valid;
                gnt       = rr_gnt;
            end
`else
            gnt_valid = rr_gnt_valid;
            gnt       = rr_gnt;
`endif
        end
    end

    // One-hot ready. All bits are zero while the buffer is stalled.
    always_comb begin
        o_in_ready = '0;
        for (int unsigned k = 0; k < P_NCH; k++) begin
            if (load_en && gnt_valid && (32'(gnt) == k)) begin
                o_in_ready[k] = 1'b1;
            end
        end
    end

    // Any granted channel is valid by construction, so a grant under
    // load_en is a transfer.
    assign in_xfer = load_en && gnt_valid;

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            data_d  = i_in_data[32'(gnt)*P_DW +: P_DW];
            ch_d    = gnt;
            valid_d = 1'b1;
            if (i_mode) begin
                ptr_d = gnt;
            end
        end else if (valid_q && i_out_ready) begin
            // Drain only: data and channel keep their last values.
            valid_d = 1'b0;
        end
    end

`ifdef MUX_RR_ARB_LOCK_EN
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (in_xfer && i_mode) begin
            lock_d    = !i_in_last[gnt];
            lock_ch_d = gnt;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            // Pointing at the last channel gives channel 0 first priority.
            ptr_q   <= P_SELW'(P_NCH - 1);
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_RR_ARB_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_out_data  = data_q;
    assign o_out_ch    = ch_q;
    assign o_out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arb
//
// Directed self-checking bench for mux_rr_arb with P_NCH=4 and P_DW=8.
// Inputs change 1 time unit after a rising edge. Outputs are sampled
// before the next rising edge.
// -----------------------------------------------------------------------------
module tb_mux_rr_arb;

    localparam int unsigned P_NCH  = 4;
    localparam int unsigned P_DW   = 8;
    localparam int unsigned P_SELW = 2;

    logic                  clk;
    logic                  rstn;
    logic                  mode;
    logic [P_SELW-1:0]     sel;
    logic [P_NCH*P_DW-1:0] in_data;
    logic [P_NCH-1:0]      in_valid;
`ifdef MUX_RR_ARB_LOCK_EN
    logic [P_NCH-1:0]      in_last;
`endif
    logic [P_NCH-1:0]      in_ready;
    logic [P_DW-1:0]       out_data;
    logic [P_SELW-1:0]     out_ch;
    logic                  out_valid;
    logic                  out_ready;

    int n_cmp = 0;
    int n_err = 0;

    mux_rr_arb #(
        .P_NCH (P_NCH),
        .P_DW  (P_DW)
    ) u_dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_mode      (mode),
        .i_sel       (sel),
        .i_in_data   (in_data),
        .i_in_valid  (in_valid),
`ifdef MUX_RR_ARB_LOCK_EN
        .i_in_last   (in_last),
`endif
        .o_in_ready  (in_ready),
        .o_out_data  (out_data),
        .o_out_ch    (out_ch),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_ch;
        logic [1:0] alt [4];

        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef MUX_RR_ARB_LOCK_EN
        in_last   = '1;
`endif
        rstn      = 1'b0;

        // ---- reset state ----
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'h00);
        check("rst_ch",    32'(out_ch),    32'd0);
        #11 rstn = 1'b1;            // release between edges (t=13)
        tick();

        // ---- fixed mode, sel=2, ch2 = A5 ----
        mode      = 1'b0;
        sel       = 2'd2;
        in_data   = {8'h13, 8'hA5, 8'h11, 8'h10};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        check("fix_ready", 32'(in_ready), 32'b0100);
        tick();
        check("fix_valid", 32'(out_valid), 32'd1);
        check("fix_data",  32'(out_data),  32'hA5);
        check("fix_ch",    32'(out_ch),    32'd2);

        // ---- fixed mode, selected channel not valid ----
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        check("fix_nogrant_ready", 32'(in_ready), 32'b0000);
        tick();
        check("fix_nogrant_valid", 32'(out_valid), 32'd0);
        check("fix_hold_data",     32'(out_data),  32'hA5);
        check("fix_hold_ch",       32'(out_ch),    32'd2);

        // ---- round robin, all valid: 0,1,2,3,0,1,2,3 ----
        mode     = 1'b1;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_ch = 2'(i % 4);
            check($sformatf("rr_all_ready%0d", i), 32'(in_ready), 32'(4'b0001 << exp_ch));
            tick();
            check($sformatf("rr_all_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("rr_all_ch%0d", i),    32'(out_ch),    32'(exp_ch));
            check($sformatf("rr_all_data%0d", i),  32'(out_data),  32'h10 + 32'(exp_ch));
        end

        // ---- round robin, ch1 and ch3 valid: 1,3,1,3 ----
        in_valid = 4'b1010;
        alt[0] = 2'd1; alt[1] = 2'd3; alt[2] = 2'd1; alt[3] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr_alt_ch%0d", i), 32'(out_ch), 32'(alt[i]));
        end
        // drop ch3: ch1 every cycle
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rr_one_ch%0d", i),    32'(out_ch),    32'd1);
            check($sformatf("rr_one_valid%0d", i), 32'(out_valid), 32'd1);
        end

        // ---- backpressure ----
        in_valid = 4'b0000;         // empty the buffer
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);
        in_data   = {8'h13, 8'h3C, 8'h11, 8'h10};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        tick();
        check("bp_load_valid", 32'(out_valid), 32'd1);
        check("bp_load_data",  32'(out_data),  32'h3C);
        in_data  = {8'h13, 8'h5A, 8'h11, 8'h10};
        in_valid = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_ready%0d", i), 32'(in_ready),  32'b0000);
            check($sformatf("bp_data%0d", i),  32'(out_data),  32'h3C);
            check($sformatf("bp_ch%0d", i),    32'(out_ch),    32'd2);
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;           // ptr=2, search 3,0 -> ch0
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd1);
        check("bp_release_data",  32'(out_data),  32'h10);
        check("bp_release_ch",    32'(out_ch),    32'd0);

        // ---- asynchronous reset mid-stream ----
        in_valid = 4'b1111;
        tick();                     // ptr now 1, buffer holds ch1
        check("pre_rst_ch", 32'(out_ch), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data",  32'(out_data),  32'h00);
        check("arst_ch",    32'(out_ch),    32'd0);
        #2 rstn = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'b0001);
        tick();
        check("post_rst_ch0", 32'(out_ch), 32'd0);
        tick();
        check("post_rst_ch1", 32'(out_ch), 32'd1);

`ifdef MUX_RR_ARB_LOCK_EN
        // ---- packet lock: ch0 sends 0,0,1 while ch1 waits ----
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        #1;
        check("lock_ready0", 32'(in_ready), 32'b0001);
        tick();
        check("lock_ch0", 32'(out_ch), 32'd0);
        check("lock_ready1", 32'(in_ready), 32'b0001);
        tick();
        check("lock_ch1", 32'(out_ch), 32'd0);
        in_last = 4'b0001;
        #1;
        check("lock_ready2", 32'(in_ready), 32'b0001);
        tick();
        check("lock_ch2", 32'(out_ch), 32'd0);
        in_last = 4'b0000;
        #1;
        check("lock_ready3", 32'(in_ready), 32'b0010);
        tick();
        check("lock_ch3", 32'(out_ch), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000, expected $finish earlier");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Parametrised N-channel, W-bit multiplexer with a valid/ready handshake on every input and on the output.
- Output is registered: a single-entry output buffer.
- Two select modes:
  - fixed: channel chosen by i_sel.
  - round-robin: fair arbitration among the valid channels.
- Sits between multiple producer streams and one consumer. It is the general-purpose successor of the week-2 combinational 2:1 mux.

Parameters:
- P_NCH, 4, number of input channels (>=2).
- P_DW, 8, data width per channel.
- P_SELW, $clog2(P_NCH), select/channel-index width (derived; do not override).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_mode  input  1  0 = fixed select via i_sel, 1 = round-robin.
- i_sel  input  P_SELW  channel index used in fixed mode.
- i_in_data  input  P_NCH*P_DW  packed input data; channel k occupies bits [k*P_DW +: P_DW].
- i_in_valid  input  P_NCH  per-channel valid.
- o_in_ready  output  P_NCH  per-channel ready (combinational).
- o_out_data  output  P_DW  registered output data.
- o_out_ch  output  P_SELW  index of the channel that produced o_out_data.
- o_out_valid  output  1  output valid.
- i_out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync release): o_out_valid=0, o_out_data=0, o_out_ch=0, RR pointer=P_NCH-1, so channel 0 has first priority.
- load_en = !o_out_valid || i_out_ready. The buffer accepts a new beat when empty or when being drained in the same cycle.
- Grant, evaluated combinationally each cycle:
  - Fixed mode: grant = i_sel if i_sel < P_NCH and i_in_valid[i_sel]. Otherwise no grant. An out-of-range i_sel never grants.
  - RR mode: grant = first k with i_in_valid[k], searching ptr+1, ptr+2, … modulo P_NCH. No valid channel gives no grant.
- o_in_ready[k] = load_en && grant_valid && (grant==k). At most one bit is set; all others are 0.
- Input transfer on channel k (valid && ready): next edge loads o_out_data=channel k data, o_out_ch=k, o_out_valid=1. Latency is 1 cycle from input transfer to o_out_valid.
- RR pointer updates to k only on an input transfer in RR mode. Fixed-mode transfers leave the pointer unchanged.
- Output transfer with no input transfer: o_out_valid goes to 0 at the next edge. o_out_data and o_out_ch hold their last values.
- Backpressure: while o_out_valid && !i_out_ready, o_out_data and o_out_ch stay stable and all o_in_ready=0.
- Simultaneous drain and load: the output stays valid with the new beat. Full throughput is 1 beat per cycle.
- Changing i_mode or i_sel affects only the next grant. The beat already held in the buffer is never altered or dropped.
- Reset asserted mid-transfer: the buffer is cleared immediately. The beat in flight is lost, which is acceptable.

Optional Feature:
- Macro MUX_RR_ARB_LOCK_EN.
- Defined:
  - Adds input port i_in_last (P_NCH bits, per-channel end-of-packet).
  - In RR mode, a transfer with last=0 locks the grant to that channel.
  - While locked, other channels get no grant even if valid, and the pointer does not advance.
  - A transferred beat with last=1 releases the lock and sets the pointer to that channel.
  - Fixed mode ignores the lock. Reset clears the lock.
- Undefined: no i_in_last port; arbitration is beat-by-beat as described above.

Test Plan:
- Fixed mode, P_NCH=4, P_DW=8: i_sel=2, valid=4'b0100, ch2 data=8'hA5, i_out_ready=1 → o_in_ready=4'b0100; next cycle o_out_valid=1, o_out_data=8'hA5, o_out_ch=2.
- Fixed mode: i_sel=1, valid=4'b1101 → o_in_ready=0, o_out_valid stays 0.
- RR mode after reset: all four valid, i_out_ready=1 for 8 cycles → o_out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
- RR mode with only ch1 and ch3 valid → grants alternate 1,3,1,3. Drop ch3 valid mid-run → ch1 is granted every cycle.
- Backpressure: o_out_valid=1 with data 8'h3C, i_out_ready=0 for 5 cycles → data and ch stable, o_in_ready=0. Raise i_out_ready → drain and new load in the same cycle, no bubble.
- Reset mid-stream: pull i_rstn low asynchronously between edges → o_out_valid=0 and o_out_data=0 immediately. After release, RR grants start at ch0.
- With MUX_RR_ARB_LOCK_EN: ch0 sends 3 beats (last=0,0,1) while ch1 is valid → out ch 0,0,0,1.
